// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and multicycle-op classification for alu_seq
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider sharing acc and counter
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] b_q, s_acc, s_lo, s_b, n_acc, n_lo;
  logic [WIDTH:0] sum, madd, shf, dif;
  logic [CW-1:0] cnt;
  logic div_q, s_div, step;
  assign done = busy & (cnt == CW'(WIDTH));
  assign step = start | (busy & ~done);
  // One iteration; the first one is folded into the start cycle so WIDTH steps end with cnt==WIDTH
  always_comb begin
    s_acc = start ? '0 : hi;
    s_lo  = start ? a : lo;
    s_b   = start ? b : b_q;
    s_div = start ? div : div_q;
    sum   = {1'b0, s_acc} + {1'b0, s_b};
    madd  = s_lo[0] ? sum : {1'b0, s_acc};
    shf   = {s_acc, s_lo[WIDTH-1]};
    dif   = shf - {1'b0, s_b};
    n_acc = s_div ? (dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0]) : madd[WIDTH:1];
    n_lo  = s_div ? {s_lo[WIDTH-2:0], ~dif[WIDTH]} : {madd[0], s_lo[WIDTH-1:1]};
  end
  // Accumulator (hi), shifting operand/quotient (lo), divisor/multiplicand and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      busy <= start | (busy & ~done);
      if (step) begin
        hi  <= n_acc;
        lo  <= n_lo;
        cnt <= start ? CW'(1) : cnt + CW'(1);
      end
      if (start) begin
        b_q   <= b;
        div_q <= div;
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result, flags and iterative MULU/DIVU
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  input  logic [3:0]       ALU_Operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);
  localparam int SHW = $clog2(WIDTH);
  state_t state, state_n;
  logic accept, mc, md_busy, md_done, dz_q, ovf, ill;
  logic [WIDTH-1:0] res, sum, dif, md_lo, md_hi;
  logic [SHW-1:0] sh;
  assign accept = in_valid & in_ready;
  assign mc = is_multicycle(ALU_Operation);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept & mc),
    .div  (ALU_Operation == OP_DIVU),
    .a    (oprd1),
    .b    (oprd2),
    .busy (md_busy),
    .done (md_done),
    .lo   (md_lo),
    .hi   (md_hi)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // Next state: a new accept wins over draining DONE to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (mc ? BUSY : DONE) : IDLE;
      BUSY:    state_n = md_done ? DONE : (md_busy ? BUSY : IDLE);
      DONE:    state_n = accept ? (mc ? BUSY : DONE) : (out_ready ? IDLE : DONE);
      default: state_n = IDLE;
    endcase
  end
  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
  end
  // Single-cycle datapath on the live operands, registered at accept
  always_comb begin
    sh  = oprd2[SHW-1:0];
    sum = oprd1 + oprd2;
    dif = oprd1 - oprd2;
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (ALU_Operation)
      OP_AND:  res = oprd1 & oprd2;
      OP_OR:   res = oprd1 | oprd2;
      OP_ADD: begin
        res = sum;
        ovf = (oprd1[WIDTH-1] == oprd2[WIDTH-1]) & (sum[WIDTH-1] != oprd1[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif;
        ovf = (oprd1[WIDTH-1] != oprd2[WIDTH-1]) & (dif[WIDTH-1] != oprd1[WIDTH-1]);
      end
      OP_SLT:  res = WIDTH'($signed(oprd1) < $signed(oprd2));
      OP_SLTU: res = WIDTH'(oprd1 < oprd2);
      OP_SLL:  res = oprd1 << sh;
      OP_SRL:  res = oprd1 >> sh;
      OP_SRA:  res = $signed(oprd1) >>> sh;
      OP_NOR:  res = ~(oprd1 | oprd2);
      OP_XOR:  res = oprd1 ^ oprd2;
      OP_MULU, OP_DIVU: res = '0;
      default: ill = 1'b1;
    endcase
  end
  // Output registers: loaded at simple-op accept or when the iterative unit finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      if (accept & mc) dz_q <= (ALU_Operation == OP_DIVU) & (oprd2 == '0);
      if (accept & ~mc) begin
        result      <= res;
        result_hi   <= '0;
        zero        <= (res == '0);
        negative    <= res[WIDTH-1];
        overflow    <= ovf;
        div_by_zero <= 1'b0;
        illegal_op  <= ill;
      end else if ((state == BUSY) & md_done) begin
        result      <= md_lo;
        result_hi   <= md_hi;
        zero        <= (md_lo == '0);
        negative    <= md_lo[WIDTH-1];
        overflow    <= 1'b0;
        div_by_zero <= dz_q;
        illegal_op  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven, hand-sequenced and randomized checks of alu_seq against a reference model
module tb_alu_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero, negative, overflow, div_by_zero, illegal_op;
  logic [31:0] oprd1 = 0, oprd2 = 0, result, result_hi;
  logic [3:0] ALU_Operation = 0;
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a, b, r, rh;
    logic [4:0]  fl;
    logic [7:0]  lat;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oprd1(oprd1), .oprd2(oprd2), .ALU_Operation(ALU_Operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .negative(negative), .overflow(overflow),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  function automatic logic [4:0] flags();
    return {zero, negative, overflow, div_by_zero, illegal_op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {zero,negative,overflow,div_by_zero,illegal_op} and results from plain arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] rh, output logic [4:0] fl,
                                output logic [7:0] lat);
    longint s;
    logic [63:0] p;
    logic v = 0, dz = 0, il = 0;
    r = 0; rh = 0; lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                 v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                 v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: r = (a < b) ? 1 : 0;
      4'b0011: r = a << b[4:0];
      4'b0100: r = a >> b[4:0];
      4'b0101: r = $signed(a) >>> b[4:0];
      4'b1100: r = ~(a | b);
      4'b1001: r = a ^ b;
      4'b1010: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; rh = p[63:32]; lat = 33; end
      4'b1101: begin
        lat = 33;
        if (b == 0) begin r = 32'hFFFF_FFFF; rh = a; dz = 1; end
        else begin r = a / b; rh = a % b; end
      end
      default: il = 1;
    endcase
    fl = {r == 0, r[31], v, dz, il};
  endfunction

  task automatic send_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1; ALU_Operation = op; oprd1 = a; oprd2 = b;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin tests++; fails++; $display("FAIL accept_timeout: in_ready stuck low"); end
    @(posedge clk); #1;
    in_valid = 0; ALU_Operation = 4'($urandom); oprd1 = $urandom; oprd2 = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    send_op(v.op, v.a, v.b);
    wait_out(lat);
    chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
    chk({nm, "_result"}, result, v.r);
    chk({nm, "_result_hi"}, result_hi, v.rh);
    chk({nm, "_flags"}, flags(), v.fl);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, rh, ea, eb, exp_b2b[4];
    logic [4:0] fl;
    logic [7:0] lat;
    logic [3:0] op;
    logic seen;
    // op, a, b, result, result_hi, {z,n,v,dz,il}, latency
    tbl.push_back('{4'b0000, 32'd12, 32'd10, 32'd8, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b0001, 32'd12, 32'd10, 32'd14, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 5'b01100, 8'd1});
    tbl.push_back('{4'b0110, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'd0, 32'd0, 5'b10000, 8'd1});
    tbl.push_back('{4'b0111, 32'hFFFF_FFFB, 32'd10, 32'd1, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b1000, 32'hFFFF_FFFB, 32'd10, 32'd0, 32'd0, 5'b10000, 8'd1});
    tbl.push_back('{4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 5'b01000, 8'd1});
    tbl.push_back('{4'b0011, 32'd1, 32'd33, 32'd2, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b0100, 32'h8000_0000, 32'd31, 32'd1, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b1001, 32'hF0, 32'hFF, 32'h0F, 32'd0, 5'b00000, 8'd1});
    tbl.push_back('{4'b1010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 5'b01000, 8'd33});
    tbl.push_back('{4'b1101, 32'd100, 32'd7, 32'd14, 32'd2, 5'b00000, 8'd33});
    tbl.push_back('{4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 5'b01010, 8'd33});
    tbl.push_back('{4'b1110, 32'd3, 32'd4, 32'd0, 32'd0, 5'b10001, 8'd1});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_flags", flags(), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    foreach (tbl[i]) run_vec($sformatf("vec%0d_op%0b", i, tbl[i].op), tbl[i]);

    // Backpressure: result held, no new accept
    out_ready = 0;
    send_op(4'b0010, 32'd15, 32'd20);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_result", result, 35);
    in_valid = 1; ALU_Operation = 4'b0001; oprd1 = 32'hAA; oprd2 = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_result%0d", i), result, 35);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);

    // Four back-to-back simple ops, one result per cycle
    exp_b2b = '{32'd3, 32'd7, 32'd6, 32'd16};
    @(negedge clk);
    in_valid = 1; ALU_Operation = 4'b0010; oprd1 = 1; oprd2 = 2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_valid%0d", i), out_valid, 1);
      chk($sformatf("b2b_result%0d", i), result, exp_b2b[i]);
      case (i)
        0: begin ALU_Operation = 4'b0110; oprd1 = 10; oprd2 = 3; end
        1: begin ALU_Operation = 4'b1001; oprd1 = 5; oprd2 = 3; end
        2: begin ALU_Operation = 4'b0011; oprd1 = 1; oprd2 = 4; end
        default: in_valid = 0;
      endcase
    end
    @(posedge clk); #1;

    // Reset during MULU aborts it
    send_op(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", flags(), 0);
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    chk("abort_no_delivery", seen, 0);
    run_vec("post_rst_nor", '{4'b1100, 32'd7, 32'd11, 32'hFFFF_FFF0, 32'd0, 5'b01000, 8'd1});
    run_vec("post_rst_illegal", '{4'b1111, 32'd9, 32'd9, 32'd0, 32'd0, 5'b10001, 8'd1});

    // Randomized against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ea = $urandom;
      eb = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) eb = eb >> $urandom_range(8, 28);
      model(op, ea, eb, r, rh, fl, lat);
      run_vec($sformatf("rnd%0d_op%0b_%0h_%0h", i, op, ea, eb), '{op, ea, eb, r, rh, fl, lat});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
